// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the instruction sequencer: opcodes, B-source modes,
// control states and instruction field layout helpers.
package cpu_seq_pkg;

    // Control opcodes (OPC[4] set); OPC[4] clear selects an ALU operation.
    localparam logic [4:0] OPC_NOP  = 5'b10000;
    localparam logic [4:0] OPC_STR  = 5'b10001;
    localparam logic [4:0] OPC_STM  = 5'b10010;
    localparam logic [4:0] OPC_JMP  = 5'b10011;
    localparam logic [4:0] OPC_JZ   = 5'b10100;
    localparam logic [4:0] OPC_JNZ  = 5'b10101;
    localparam logic [4:0] OPC_CALL = 5'b10110;
    localparam logic [4:0] OPC_RET  = 5'b10111;
    localparam logic [4:0] OPC_HLT  = 5'b11000;

    // MODE field: B-input source; MODE[1] selects memory.
    localparam logic [1:0] MODE_IMM     = 2'b00;
    localparam logic [1:0] MODE_REG     = 2'b01;
    localparam logic [1:0] MODE_MEM_DIR = 2'b10;
    localparam logic [1:0] MODE_MEM_IND = 2'b11;

    typedef enum logic [1:0] {ST_START, ST_RUN, ST_HALT, ST_ERR} state_t;

    // Instruction layout: {OPC, MODE[1:0], OPERAND[WIDTH-1:0]}
    localparam int MODE_W      = 2;
    localparam int OPERAND_LSB = 0;

    function automatic int mode_lsb(input int width);
        return width;
    endfunction

    function automatic int opc_lsb(input int width);
        return width + MODE_W;
    endfunction

endpackage

// File: rtl/cpu_ret_stack.sv
// Return-address LIFO for CALL/RET. Pushes while full and pops while empty
// are ignored; the caller turns those cases into a fault.
module cpu_ret_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   sp;
    logic [SPW-1:0]   sp_m1;

    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);
    assign sp_m1 = sp - SPW'(1);
    assign top   = mem[sp_m1[AW-1:0]];

    // Stack pointer: count entries, reset to empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sp <= '0;
        else if (push && !full)
            sp <= sp + SPW'(1);
        else if (pop && !empty)
            sp <= sp_m1;
    end

    // Entry storage: contents need no reset, SP defines validity
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[sp[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cpu_seq.sv
// Instruction sequencer / control unit: PC, fetch address, decode to
// datapath controls, Z-flag branches, CALL/RET stack, run/halt/error FSM.
// Optional macro SINGLE_STEP_EN adds a STEP input that executes one
// instruction per STEP rising edge.
module cpu_seq
    import cpu_seq_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int IWIDTH         = 5,
    parameter int REG_F_SEL_SIZE = 4,
    parameter int IN_B_SEL_SIZE  = 2,
    parameter int STACK_DEPTH    = 4
) (
    input  logic                       CLK,
    input  logic                       RST_N,
`ifdef SINGLE_STEP_EN
    input  logic                       STEP,
`endif
    input  logic [IWIDTH+2+WIDTH-1:0]  INSTR,
    output logic [WIDTH-1:0]           PROG_ADDR,
    input  logic                       Z,
    output logic [REG_F_SEL_SIZE-1:0]  REG_F_SEL,
    output logic                       EN_REG_F,
    output logic [WIDTH-1:0]           D_MEM_ADDR,
    output logic                       D_MEM_ADDR_MODE,
    output logic                       EN_D_MEM,
    output logic [IN_B_SEL_SIZE-1:0]   IN_B_SEL,
    output logic [WIDTH-1:0]           IMM,
    output logic [IWIDTH-2:0]          ALU_OUT,
    output logic                       EN_ACC,
    output logic                       HALTED,
    output logic                       ERR
);
    localparam int MODE_LSB = mode_lsb(WIDTH);
    localparam int OPC_LSB  = opc_lsb(WIDTH);

    state_t            state;
    logic [WIDTH-1:0]  pc;
    logic              halted_q;
    logic              err_q;

    logic [IWIDTH-1:0] opc;
    logic [1:0]        mode;
    logic [WIDTH-1:0]  operand;

    logic              exec;
    logic              dec_acc, dec_reg, dec_dmem;
    logic              dec_push, dec_pop, dec_halt, dec_fault;
    logic [WIDTH-1:0]  pc_next;
    logic [WIDTH-1:0]  stk_top;
    logic              stk_full, stk_empty;

    assign opc     = INSTR[OPC_LSB +: IWIDTH];
    assign mode    = INSTR[MODE_LSB +: MODE_W];
    assign operand = INSTR[OPERAND_LSB +: WIDTH];

`ifdef SINGLE_STEP_EN
    logic [2:0] step_sync;

    // STEP synchronizer (two flops) plus one history flop for edge detect
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            step_sync <= '0;
        else
            step_sync <= {step_sync[1:0], STEP};
    end

    // RUN idles (paused) until a STEP rising edge grants one instruction
    assign exec = (state == ST_RUN) && step_sync[1] && !step_sync[2];
`else
    assign exec = (state == ST_RUN);
`endif

    // Field outputs are plain pass-through of the fetched word
    assign PROG_ADDR       = pc;
    assign REG_F_SEL       = operand[REG_F_SEL_SIZE-1:0];
    assign D_MEM_ADDR      = operand;
    assign D_MEM_ADDR_MODE = (mode == MODE_MEM_IND);
    assign IN_B_SEL        = mode;
    assign IMM             = operand;
    assign ALU_OUT         = opc[IWIDTH-2:0];

    // Enables drop the moment state leaves RUN (incl. async reset)
    assign EN_ACC   = exec && dec_acc;
    assign EN_REG_F = exec && dec_reg;
    assign EN_D_MEM = exec && dec_dmem;
    assign HALTED   = halted_q;
    assign ERR      = err_q;

    // Decode the current word into enables, stack ops and next PC
    always_comb begin
        dec_acc   = 1'b0;
        dec_reg   = 1'b0;
        dec_dmem  = 1'b0;
        dec_push  = 1'b0;
        dec_pop   = 1'b0;
        dec_halt  = 1'b0;
        dec_fault = 1'b0;
        pc_next   = pc + WIDTH'(1);
        if (!opc[IWIDTH-1]) begin
            dec_acc = 1'b1;
        end else begin
            case (opc)
                OPC_STR:  dec_reg  = 1'b1;
                OPC_STM:  dec_dmem = mode[1];
                OPC_JMP:  pc_next  = operand;
                OPC_JZ:   if (Z)  pc_next = operand;
                OPC_JNZ:  if (!Z) pc_next = operand;
                OPC_CALL: begin
                    if (stk_full) begin
                        dec_fault = 1'b1;
                        pc_next   = pc;
                    end else begin
                        dec_push = 1'b1;
                        pc_next  = operand;
                    end
                end
                OPC_RET: begin
                    if (stk_empty) begin
                        dec_fault = 1'b1;
                        pc_next   = pc;
                    end else begin
                        dec_pop = 1'b1;
                        pc_next = stk_top;
                    end
                end
                OPC_HLT: begin
                    dec_halt = 1'b1;
                    pc_next  = pc;
                end
                default: ;
            endcase
        end
    end

    // Control FSM with PC and registered status outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_START;
            pc       <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_START: state <= ST_RUN;
                ST_RUN: begin
                    if (exec) begin
                        pc <= pc_next;
                        if (dec_fault) begin
                            state    <= ST_ERR;
                            halted_q <= 1'b1;
                            err_q    <= 1'b1;
                        end else if (dec_halt) begin
                            state    <= ST_HALT;
                            halted_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    cpu_ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (exec && dec_push),
        .pop       (exec && dec_pop),
        .push_data (pc + WIDTH'(1)),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

endmodule

// File: tb/tb_cpu_seq.sv
// Self-checking bench for cpu_seq (default build, STEP unused).
module tb_cpu_seq;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        Z = 1'b0;
    logic        STEP = 1'b0;
    logic [14:0] INSTR;
    logic [7:0]  PROG_ADDR, D_MEM_ADDR, IMM;
    logic [3:0]  REG_F_SEL, ALU_OUT;
    logic [1:0]  IN_B_SEL;
    logic        EN_REG_F, D_MEM_ADDR_MODE, EN_D_MEM, EN_ACC, HALTED, ERR;

    cpu_seq dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
`ifdef SINGLE_STEP_EN
        .STEP            (STEP),
`endif
        .INSTR           (INSTR),
        .PROG_ADDR       (PROG_ADDR),
        .Z               (Z),
        .REG_F_SEL       (REG_F_SEL),
        .EN_REG_F        (EN_REG_F),
        .D_MEM_ADDR      (D_MEM_ADDR),
        .D_MEM_ADDR_MODE (D_MEM_ADDR_MODE),
        .EN_D_MEM        (EN_D_MEM),
        .IN_B_SEL        (IN_B_SEL),
        .IMM             (IMM),
        .ALU_OUT         (ALU_OUT),
        .EN_ACC          (EN_ACC),
        .HALTED          (HALTED),
        .ERR             (ERR)
    );

    always #5 CLK = ~CLK;

    localparam logic [4:0] NOP = 5'b10000, STR = 5'b10001, STM = 5'b10010,
                           JMP = 5'b10011, JZ = 5'b10100, JNZ = 5'b10101,
                           CALL = 5'b10110, RET = 5'b10111, HLT = 5'b11000,
                           ALU3 = 5'b00011, BAD = 5'b11111;

    // flags = {EN_ACC, EN_REG_F, EN_D_MEM}
    typedef struct {
        logic [14:0] ins;
        logic        z;
        logic [2:0]  fl;
        logic [7:0]  npc;
    } vec_t;

    typedef struct {
        string       name;
        logic [2:0]  fl;
        logic [26:0] fields;
        logic [7:0]  npc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    vec_t tbl[20];

    function automatic logic [14:0] mk(input logic [4:0] o, input logic [1:0] m,
                                       input logic [7:0] d);
        return {o, m, d};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    // Drive one instruction, check decode before the edge and PC after it
    task automatic run_instr(input string nm, input logic [14:0] ins, input logic z,
                             input logic [2:0] fl, input logic [7:0] npc);
        exp_t e;
        @(negedge CLK);
        INSTR = ins;
        Z     = z;
        exp_q.push_back('{nm, fl,
            {ins[13:10], ins[9:8], ins[3:0], (ins[9:8] == 2'b11), ins[7:0], ins[7:0]}, npc});
        #1;
        e = exp_q.pop_front();
        chk({e.name, " enables"}, {29'd0, EN_ACC, EN_REG_F, EN_D_MEM}, {29'd0, e.fl});
        chk({e.name, " fields"},
            {5'd0, ALU_OUT, IN_B_SEL, REG_F_SEL, D_MEM_ADDR_MODE, IMM, D_MEM_ADDR},
            {5'd0, e.fields});
        @(posedge CLK);
        #1;
        chk({e.name, " pc"}, {24'd0, PROG_ADDR}, {24'd0, e.npc});
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        INSTR = mk(NOP, 2'b00, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("reset pc", {24'd0, PROG_ADDR}, 32'd0);
        chk("reset status", {30'd0, HALTED, ERR}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{mk(NOP,  2'b00, 8'h00), 1'b0, 3'b000, 8'h01};
        tbl[1]  = '{mk(NOP,  2'b00, 8'h00), 1'b0, 3'b000, 8'h02};
        tbl[2]  = '{mk(JMP,  2'b00, 8'h10), 1'b0, 3'b000, 8'h10};
        tbl[3]  = '{mk(JZ,   2'b00, 8'h40), 1'b1, 3'b000, 8'h40};
        tbl[4]  = '{mk(JMP,  2'b00, 8'h10), 1'b0, 3'b000, 8'h10};
        tbl[5]  = '{mk(JZ,   2'b00, 8'h40), 1'b0, 3'b000, 8'h11};
        tbl[6]  = '{mk(JMP,  2'b00, 8'h10), 1'b0, 3'b000, 8'h10};
        tbl[7]  = '{mk(JNZ,  2'b00, 8'h40), 1'b0, 3'b000, 8'h40};
        tbl[8]  = '{mk(JMP,  2'b00, 8'h10), 1'b1, 3'b000, 8'h10};
        tbl[9]  = '{mk(JNZ,  2'b00, 8'h40), 1'b1, 3'b000, 8'h11};
        tbl[10] = '{mk(ALU3, 2'b01, 8'h03), 1'b0, 3'b100, 8'h12};
        tbl[11] = '{mk(STR,  2'b00, 8'h05), 1'b0, 3'b010, 8'h13};
        tbl[12] = '{mk(STM,  2'b11, 8'h02), 1'b0, 3'b001, 8'h14};
        tbl[13] = '{mk(STM,  2'b00, 8'h02), 1'b0, 3'b000, 8'h15};
        tbl[14] = '{mk(BAD,  2'b10, 8'h9A), 1'b0, 3'b000, 8'h16};
        tbl[15] = '{mk(JMP,  2'b00, 8'h05), 1'b0, 3'b000, 8'h05};
        tbl[16] = '{mk(CALL, 2'b00, 8'h20), 1'b0, 3'b000, 8'h20};
        tbl[17] = '{mk(RET,  2'b00, 8'h00), 1'b0, 3'b000, 8'h06};
        tbl[18] = '{mk(JMP,  2'b00, 8'hFF), 1'b0, 3'b000, 8'hFF};
        tbl[19] = '{mk(NOP,  2'b00, 8'h00), 1'b0, 3'b000, 8'h00};

        // Reset state with an ALU op presented: nothing may be enabled
        INSTR = mk(ALU3, 2'b01, 8'h03);
        #12;
        chk("rst enables", {29'd0, EN_ACC, EN_REG_F, EN_D_MEM}, 32'd0);
        chk("rst pc", {24'd0, PROG_ADDR}, 32'd0);
        chk("rst status", {30'd0, HALTED, ERR}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("start enables", {29'd0, EN_ACC, EN_REG_F, EN_D_MEM}, 32'd0);
        @(posedge CLK);
        #1;
        chk("start pc held", {24'd0, PROG_ADDR}, 32'd0);

        for (int i = 0; i < 20; i++)
            run_instr($sformatf("vec%0d", i), tbl[i].ins, tbl[i].z, tbl[i].fl, tbl[i].npc);

        // Nested CALLs: four fill the stack, the fifth faults
        for (int i = 0; i < 4; i++)
            run_instr($sformatf("call%0d", i), mk(CALL, 2'b00, 8'h30), 1'b0, 3'b000, 8'h30);
        run_instr("call overflow", mk(CALL, 2'b00, 8'h30), 1'b0, 3'b000, 8'h30);
        chk("overflow status", {30'd0, HALTED, ERR}, 32'd3);
        run_instr("err jmp", mk(JMP, 2'b00, 8'h77), 1'b0, 3'b000, 8'h30);
        run_instr("err alu", mk(ALU3, 2'b01, 8'h03), 1'b0, 3'b000, 8'h30);

        // RET on empty stack
        do_reset();
        run_instr("ret underflow", mk(RET, 2'b00, 8'h00), 1'b0, 3'b000, 8'h00);
        chk("underflow status", {30'd0, HALTED, ERR}, 32'd3);
        run_instr("uf alu", mk(ALU3, 2'b01, 8'h03), 1'b0, 3'b000, 8'h00);
        run_instr("uf jmp", mk(JMP, 2'b00, 8'h44), 1'b0, 3'b000, 8'h00);

        // HLT freezes PC
        do_reset();
        run_instr("jmp 7f", mk(JMP, 2'b00, 8'h7F), 1'b0, 3'b000, 8'h7F);
        run_instr("hlt", mk(HLT, 2'b00, 8'h00), 1'b0, 3'b000, 8'h7F);
        chk("halt status", {30'd0, HALTED, ERR}, 32'd2);
        run_instr("halt alu", mk(ALU3, 2'b01, 8'h03), 1'b0, 3'b000, 8'h7F);

        // Mid-cycle reset kills an in-flight enable without a clock edge
        do_reset();
        run_instr("jmp 7f b", mk(JMP, 2'b00, 8'h7F), 1'b0, 3'b000, 8'h7F);
        @(negedge CLK);
        INSTR = mk(ALU3, 2'b01, 8'h03);
        #1;
        chk("pre-reset en_acc", {31'd0, EN_ACC}, 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async en_acc", {31'd0, EN_ACC}, 32'd0);
        chk("async pc", {24'd0, PROG_ADDR}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_seq.md
Name: cpu_seq

Overview:
Instruction sequencer and control unit directly upstream of the CPU datapath. It holds the program counter and fetches one instruction word per cycle from an external asynchronous-read program ROM. It decodes that word into the datapath control set (register-file select/enable, data-memory address/enable, B-input select, immediate, ALU opcode, accumulator enable) and branches on the datapath Z flag. A return-address stack supports CALL/RET, and a run/halt/error state machine governs execution.

Parameters:
WIDTH, 8, data/immediate/address width; PC width equals WIDTH
IWIDTH, 5, opcode width; ALU code is IWIDTH-1 bits
REG_F_SEL_SIZE, 4, register-file select width
IN_B_SEL_SIZE, 2, B-input mux select width
STACK_DEPTH, 4, return-stack entries (power of 2, minimum 2)

Ports:
CLK  in  1  rising-edge clock
RST_N  in  1  asynchronous active-low reset
INSTR  in  IWIDTH+2+WIDTH  {OPC, MODE[1:0], OPERAND}, combinationally valid for PROG_ADDR
PROG_ADDR  out  WIDTH  program ROM address (= PC)
Z  in  1  registered zero flag from datapath
REG_F_SEL  out  REG_F_SEL_SIZE  register select (= OPERAND[3:0])
EN_REG_F  out  1  register-file write enable
D_MEM_ADDR  out  WIDTH  direct data-memory address (= OPERAND)
D_MEM_ADDR_MODE  out  1  1 = address from register (MODE==11)
EN_D_MEM  out  1  data-memory write enable
IN_B_SEL  out  IN_B_SEL_SIZE  00 IMM, 01 REG, 1x MEM (= MODE)
IMM  out  WIDTH  immediate (= OPERAND)
ALU_OUT  out  IWIDTH-1  ALU opcode (= OPC[3:0])
EN_ACC  out  1  accumulator write enable
HALTED  out  1  state is HALT or ERR
ERR  out  1  state is ERR (stack fault)

Behaviour:
- Reset (RST_N low, asynchronous): PC=0, stack pointer SP=0, state=START. All enables 0, HALTED=0, ERR=0.
- States: START -> RUN on the first CLK edge after reset release. START holds PC and keeps enables at 0, giving the datapath flag register one clean cycle.
- RUN -> HALT on HLT. RUN -> ERR on stack overflow or underflow. HALT and ERR are exited only by reset.
- Control outputs are combinational from INSTR. All enables are gated by state==RUN. Field outputs (IMM, D_MEM_ADDR, REG_F_SEL, IN_B_SEL, ALU_OUT) pass through ungated.
- Single-cycle execution: instruction at PC takes effect on the same CLK edge that advances PC.
- OPC[4]=0: ALU op. EN_ACC=1; ALU_OUT=OPC[3:0]; B source per MODE.
- Control opcodes (OPC[4]=1):
  - 10000 NOP.
  - 10001 STR: EN_REG_F=1.
  - 10010 STM: EN_D_MEM=1; direct address if MODE=10, indirect if MODE=11. For MODE 0x, STM behaves as NOP.
  - 10011 JMP: PC<=OPERAND.
  - 10100 JZ: PC<=OPERAND if Z=1, else PC+1.
  - 10101 JNZ: PC<=OPERAND if Z=0, else PC+1.
  - 10110 CALL: stack[SP]<=PC+1, SP<=SP+1, PC<=OPERAND.
  - 10111 RET: SP<=SP-1, PC<=stack[SP-1].
  - 11000 HLT: PC held.
  - All other codes execute as NOP.
- Default next PC is PC+1 modulo 2^WIDTH; 255 wraps to 0 with no flag.
- Z is sampled in the same cycle as the branch. A JZ following an ALU op sees the flag produced by that op, since the flag register updates on the same edge as the PC.
- CALL with SP==STACK_DEPTH: overflow. No push; state ERR; PC held.
- RET with SP==0: underflow. State ERR; PC held.
- In HALT/ERR: PC, SP, and stack frozen; INSTR ignored.
- Reset asserted mid-instruction: in-flight writes are suppressed immediately, since enables drop combinationally when state leaves RUN.

Optional Feature:
SINGLE_STEP_EN: adds input STEP (1 bit).
- With the macro: RUN waits in a PAUSE sub-state with enables 0. A STEP rising edge, detected by a 2-flop synchronizer plus edge detector, executes exactly one instruction, then returns to PAUSE. STEP held high executes only once.
- Without the macro: no STEP port, and RUN executes one instruction every cycle.

Decomposition:
Shared package cpu_seq_pkg:
- opcode localparams: OPC_NOP, OPC_STR, OPC_STM, OPC_JMP, OPC_JZ, OPC_JNZ, OPC_CALL, OPC_RET, OPC_HLT
- MODE encodings: MODE_IMM, MODE_REG, MODE_MEM_DIR, MODE_MEM_IND
- state encoding: ST_START, ST_RUN, ST_HALT, ST_ERR
- instruction field offsets
One sub-module, cpu_ret_stack: LIFO with push/pop, full/empty, and a registered SP.

Test Plan:
1. Reset release, then INSTR=NOP each cycle -> PROG_ADDR 0,0,1,2,3 (START cycle holds 0); all enables 0 during START.
2. PC=0x10: JZ 0x40 with Z=1 -> PC=0x40; with Z=0 -> PC=0x11. JNZ is the mirror case.
3. CALL 0x20 at PC=0x05, then RET -> PC=0x20 then 0x06. Five nested CALLs with STACK_DEPTH=4 -> 5th sets ERR=1, HALTED=1, PC frozen at the 5th CALL's address.
4. RET at SP=0 -> ERR=1 next cycle; later INSTR changes cause no PC motion and no enables.
5. ALU op OPC=00011 MODE=01 OPERAND=0x03 -> EN_ACC=1, ALU_OUT=3, IN_B_SEL=01, REG_F_SEL=3. STM MODE=11 OPERAND=0x02 -> EN_D_MEM=1, D_MEM_ADDR_MODE=1.
6. HLT at PC=0x7F -> HALTED=1, PC stays 0x7F. Assert RST_N low mid-cycle -> enables 0 and PC=0 immediately, without waiting for a clock edge.
